// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_scancode_rx                                                |
// | Brief   : PS/2 keyboard frame receiver with E0/F0 prefix folding and a   |
// |           first-word fall-through scancode FIFO.                         |
// | Option  : define PS2_RX_TIMEOUT_EN to abort stalled partial frames.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_scancode_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk_k,
  input  logic                          reset_l,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [9:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  logic [1:0]             state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic                   ext_pend;
  logic                   brk_pend;
  logic                   timeout;

  logic                   frame_done;
  logic                   parity_ok;
  logic                   frame_good;
  logic                   code_ext;
  logic                   code_brk;
  logic                   push_req;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   do_push;
  logic                   do_pop;

  // Synchronisers reset to the idle-high level so reset release never looks like a fall.
  always_ff @(posedge clk_k or negedge reset_l) begin
    if (!reset_l) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  always_comb begin
    frame_done = fall && (state == ST_STOP);
    parity_ok  = ^{shreg, par_bit};
    frame_good = frame_done && data_s && parity_ok;
    code_ext   = (shreg == 8'hE0);
    code_brk   = (shreg == 8'hF0);
    push_req   = frame_good && !code_ext && !code_brk;
  end

  always_ff @(posedge clk_k or negedge reset_l) begin
    if (!reset_l) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout) begin
        state     <= ST_IDLE;
        shreg     <= 8'h00;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (frame_good) begin
              if (code_ext) begin
                ext_pend <= 1'b1;
              end else if (code_brk) begin
                brk_pend <= 1'b1;
              end else begin
                // Cleared whether or not the FIFO had room for the code.
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
              end
            end else begin
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
              if (!parity_ok) begin
                parity_err <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_k or negedge reset_l) begin
    if (!reset_l) begin
      wd_cnt <= '0;
    end else if (fall || timeout || (state == ST_IDLE)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state != ST_IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = rd_en && (count != '0);
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk_k or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 10'h000;
      end
    end else begin
      overflow <= push_req && !do_push;
      if (do_push) begin
        mem[wr_ptr] <= {ext_pend, brk_pend, shreg};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = mem[rd_ptr];
  assign fifo_count = count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ps2_scancode_rx                                             |
// | Brief   : Directed self-checking bench for ps2_scancode_rx.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ps2_scancode_rx;
  localparam int FIFO_DEPTH  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 5000;
  localparam int HALF        = 20;

  logic       clk_k    = 1'b0;
  logic       reset_l  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en    = 1'b0;
  logic       rd_valid;
  logic [9:0] rd_data;
  logic [3:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int perr_n    = 0;
  int ferr_n    = 0;
  int ovf_n     = 0;
  int ovf_cyc   = -1;
  int ferr_cyc  = -1;
  int drive_cyc = 0;

  ps2_scancode_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_k      (clk_k),
    .reset_l    (reset_l),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk_k = ~clk_k;

  always @(posedge clk_k) cyc <= cyc + 1;

  always @(negedge clk_k) begin
    if (parity_err) perr_n <= perr_n + 1;
    if (frame_err) begin
      ferr_n   <= ferr_n + 1;
      ferr_cyc <= cyc;
    end
    if (overflow) begin
      ovf_n   <= ovf_n + 1;
      ovf_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit; optionally pulses rd_en pop_at cycles after the falling edge is driven.
  task automatic ps2_bit(input logic b, input int pop_at);
    @(negedge clk_k);
    ps2_data = b;
    repeat (HALF) @(negedge clk_k);
    ps2_clk   = 1'b0;
    drive_cyc = cyc;
    if (pop_at >= 0) begin
      repeat (pop_at) @(negedge clk_k);
      rd_en = 1'b1;
      @(negedge clk_k);
      rd_en = 1'b0;
      repeat (HALF - pop_at - 1) @(negedge clk_k);
    end else begin
      repeat (HALF) @(negedge clk_k);
    end
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk_k);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par,
                            input logic stop, input int pop_at);
    logic p;
    p = ~(^code) ^ bad_par;
    ps2_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], -1);
    ps2_bit(p, -1);
    ps2_bit(stop, pop_at);
    repeat (5) @(negedge clk_k);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0, -1);
    repeat (nbits) ps2_bit(1'b1, -1);
  endtask

  task automatic pop_one();
    @(negedge clk_k);
    rd_en = 1'b1;
    @(negedge clk_k);
    rd_en = 1'b0;
  endtask

  initial begin
    int p0, f0, o0, lat, pop_at;
    logic [7:0] drain_exp [8];
    drain_exp = '{8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1F};

    repeat (4) @(negedge clk_k);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_count", fifo_count, 4'd0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    reset_l = 1'b1;
    repeat (10) @(negedge clk_k);
    check("post_reset_count", fifo_count, 4'd0);

    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("t1_valid", rd_valid, 1'b1);
    check("t1_data", rd_data, 10'h01C);
    check("t1_count", fifo_count, 4'd1);
    pop_one();
    check("t1_pop_count", fifo_count, 4'd0);
    check("t1_pop_valid", rd_valid, 1'b0);

    send_frame(8'hF0, 1'b0, 1'b1, -1);
    check("brk_prefix_no_push", fifo_count, 4'd0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("brk_count", fifo_count, 4'd1);
    check("brk_data", rd_data, 10'h11C);
    pop_one();
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    check("ext_brk_count", fifo_count, 4'd1);
    check("ext_brk_data", rd_data, 10'h375);
    pop_one();

    p0 = perr_n;
    f0 = ferr_n;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check("parity_pulse", perr_n - p0, 1);
    check("parity_no_frame_err", ferr_n - f0, 0);
    check("parity_no_push", fifo_count, 4'd0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("after_parity_data", rd_data, 10'h01C);
    pop_one();

    f0 = ferr_n;
    p0 = perr_n;
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    check("stop_frame_err", ferr_n - f0, 1);
    check("stop_no_parity_err", perr_n - p0, 0);
    check("stop_no_push", fifo_count, 4'd0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("err_clears_ext", rd_data, 10'h01C);
    pop_one();

    f0 = ferr_n;
    p0 = perr_n;
    ps2_bit(1'b1, -1);
    check("glitch_no_push", fifo_count, 4'd0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("glitch_then_data", rd_data, 10'h01C);
    check("glitch_no_errs", (ferr_n - f0) + (perr_n - p0), 0);
    pop_one();

    o0 = ovf_n;
    for (int i = 0; i < 9; i++) send_frame(8'h16 + 8'(i), 1'b0, 1'b1, -1);
    lat = ovf_cyc - drive_cyc;
    check("full_count", fifo_count, 4'd8);
    check("overflow_pulse", ovf_n - o0, 1);
    check("full_head", rd_data, 10'h016);
    check("push_latency_sane", (lat >= 1 && lat < HALF), 1'b1);
    pop_at = (lat >= 1 && lat < HALF) ? lat - 1 : 2;
    send_frame(8'h1F, 1'b0, 1'b1, pop_at);
    check("full_push_pop_count", fifo_count, 4'd8);
    check("full_push_pop_no_ovf", ovf_n - o0, 1);
    check("full_push_pop_head", rd_data, 10'h017);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", rd_data, {2'b00, drain_exp[i]});
      pop_one();
    end
    check("drain_empty", fifo_count, 4'd0);

    send_frame(8'h1C, 1'b0, 1'b1, -1);
    send_partial(3);
    @(negedge clk_k);
    reset_l = 1'b0;
    repeat (3) @(negedge clk_k);
    check("midreset_count", fifo_count, 4'd0);
    check("midreset_valid", rd_valid, 1'b0);
    reset_l = 1'b1;
    repeat (5) @(negedge clk_k);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("midreset_recover_count", fifo_count, 4'd1);
    check("midreset_recover_data", rd_data, 10'h01C);
    pop_one();

`ifdef PS2_RX_TIMEOUT_EN
    f0 = ferr_n;
    send_partial(3);
    begin
      int fall_cyc, waited;
      fall_cyc = drive_cyc;
      waited   = 0;
      while (ferr_n == f0 && waited < TIMEOUT_CYC + 200) begin
        @(negedge clk_k);
        waited++;
      end
      check("timeout_pulse", ferr_n - f0, 1);
      check("timeout_delay_ok",
            (ferr_cyc - fall_cyc >= TIMEOUT_CYC) && (ferr_cyc - fall_cyc <= TIMEOUT_CYC + 10), 1'b1);
    end
    check("timeout_no_push", fifo_count, 4'd0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("timeout_recover_data", rd_data, 10'h01C);
    check("timeout_recover_count", fifo_count, 4'd1);
    pop_one();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
`default_nettype wire
